// File: rtl/cell_in_buffer_pkg.sv
// cell_in_buffer_pkg: bank state encoding and gate index constants shared by the gate buffer
package cell_in_buffer_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    localparam int GATE_I = 0;
    localparam int GATE_F = 1;
    localparam int GATE_G = 2;
    localparam int GATE_O = 3;

    function automatic logic bank_open(input bank_state_t s);
        return s == BANK_EMPTY || s == BANK_FILLING;
    endfunction

endpackage

// File: rtl/cell_in_buffer_bank.sv
// cell_bank: one ping-pong bank holding a timestep of gate pre-activations, its fill count and state
module cell_bank
    import cell_in_buffer_pkg::*;
#(
    parameter int ELEMENT_BITS = 8,
    parameter int FEATURES     = 4,
    parameter int FEATURE_BITS = 4
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    we,
    input  logic [FEATURE_BITS-1:0] wr_addr,
    input  logic [ELEMENT_BITS-1:0] wr_data,
    input  logic                    start_drain,
    input  logic                    finish_drain,
    input  logic [FEATURE_BITS-1:0] rd_feature,
    output bank_state_t             state,
    output logic                    last_write,
    output logic [ELEMENT_BITS-1:0] rd_i,
    output logic [ELEMENT_BITS-1:0] rd_f,
    output logic [ELEMENT_BITS-1:0] rd_g,
    output logic [ELEMENT_BITS-1:0] rd_o
);

    localparam int M     = 4 * FEATURES;
    localparam int DEPTH = 1 << FEATURE_BITS;

    logic [ELEMENT_BITS-1:0] mem [DEPTH];
    logic [FEATURE_BITS-1:0] count, count_next;
    bank_state_t             state_next;

    // the write that completes the bank is the M-th accepted strobe, regardless of address
    assign last_write = count == FEATURE_BITS'(M - 1);

    always_comb begin
        state_next = state;
        count_next = count;
        if (we) begin
            count_next = last_write ? '0 : count + 1'b1;
            state_next = last_write ? BANK_FULL : BANK_FILLING;
        end else if (start_drain && state == BANK_FULL)
            state_next = BANK_DRAINING;
        else if (finish_drain && state == BANK_DRAINING)
            state_next = BANK_EMPTY;
    end

    always_ff @(posedge sys_clk) begin
        if (reset || clear) begin
            state <= BANK_EMPTY;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_ff @(posedge sys_clk)
        if (we) mem[wr_addr] <= wr_data;

    assign rd_i = mem[FEATURE_BITS'(GATE_I * FEATURES) + rd_feature];
    assign rd_f = mem[FEATURE_BITS'(GATE_F * FEATURES) + rd_feature];
    assign rd_g = mem[FEATURE_BITS'(GATE_G * FEATURES) + rd_feature];
    assign rd_o = mem[FEATURE_BITS'(GATE_O * FEATURES) + rd_feature];

endmodule

// File: rtl/cell_in_buffer.sv
// cell_in_buffer: ping-pong buffer turning systolic gate outputs into per-feature i/f/g/o quadruples
module cell_in_buffer
    import cell_in_buffer_pkg::*;
#(
    parameter int ELEMENT_BITS = 8,
    parameter int FEATURES     = 4,
    parameter int FEATURE_BITS = 4
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic [ELEMENT_BITS-1:0] load_data,
    input  logic [FEATURE_BITS-1:0] load_address,
    input  logic                    load_we,
    input  logic                    clear,
    output logic [ELEMENT_BITS-1:0] gate_i,
    output logic [ELEMENT_BITS-1:0] gate_f,
    output logic [ELEMENT_BITS-1:0] gate_g,
    output logic [ELEMENT_BITS-1:0] gate_o,
    output logic [FEATURE_BITS-1:0] feature_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    last,
    output logic                    load_full,
    output logic                    err
);

    localparam int M = 4 * FEATURES;

    bank_state_t             st [2];
    logic [ELEMENT_BITS-1:0] rd_i [2];
    logic [ELEMENT_BITS-1:0] rd_f [2];
    logic [ELEMENT_BITS-1:0] rd_g [2];
    logic [ELEMENT_BITS-1:0] rd_o [2];
    logic [1:0]              last_write, bank_we, start_drain, finish_drain;
    logic                    wr_bank, rd_bank, next_rd_bank;
    logic                    addr_ok, accept, handshake, finish, chain, start, load;
    logic [FEATURE_BITS-1:0] next_feature;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cell_bank #(
            .ELEMENT_BITS(ELEMENT_BITS),
            .FEATURES    (FEATURES),
            .FEATURE_BITS(FEATURE_BITS)
        ) u_bank (
            .sys_clk     (sys_clk),
            .reset       (reset),
            .clear       (clear),
            .we          (bank_we[b]),
            .wr_addr     (load_address),
            .wr_data     (load_data),
            .start_drain (start_drain[b]),
            .finish_drain(finish_drain[b]),
            .rd_feature  (next_feature),
            .state       (st[b]),
            .last_write  (last_write[b]),
            .rd_i        (rd_i[b]),
            .rd_f        (rd_f[b]),
            .rd_g        (rd_g[b]),
            .rd_o        (rd_o[b])
        );
    end

    // both banks share one read address; the bank that will own the next quadruple is muxed afterwards
    always_comb begin
        addr_ok      = {1'b0, load_address} < (FEATURE_BITS + 1)'(M);
        accept       = load_we && !clear && addr_ok && bank_open(st[wr_bank]);
        handshake    = out_valid && out_ready;
        finish       = handshake && last;
        chain        = finish && st[!rd_bank] == BANK_FULL;
        start        = !out_valid && st[rd_bank] == BANK_FULL;
        load         = start || (handshake && !last) || chain;
        next_rd_bank = finish ? !rd_bank : rd_bank;
        next_feature = (handshake && !last) ? feature_idx + 1'b1 : '0;
        bank_we      = accept ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
        finish_drain = finish ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
        start_drain  = start ? (rd_bank ? 2'b10 : 2'b01) : chain ? (rd_bank ? 2'b01 : 2'b10) : 2'b00;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            feature_idx <= '0;
            out_valid   <= 1'b0;
            last        <= 1'b0;
            err         <= 1'b0;
            gate_i      <= '0;
            gate_f      <= '0;
            gate_g      <= '0;
            gate_o      <= '0;
        end else if (clear) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            feature_idx <= '0;
            out_valid   <= 1'b0;
            last        <= 1'b0;
        end else begin
            if (accept && last_write[wr_bank]) wr_bank <= !wr_bank;
            if (load_we && !accept) err <= 1'b1;
            rd_bank <= next_rd_bank;
            if (load) begin
                out_valid   <= 1'b1;
                feature_idx <= next_feature;
                last        <= next_feature == FEATURE_BITS'(FEATURES - 1);
                gate_i      <= rd_i[next_rd_bank];
                gate_f      <= rd_f[next_rd_bank];
                gate_g      <= rd_g[next_rd_bank];
                gate_o      <= rd_o[next_rd_bank];
            end else if (finish) begin
                out_valid <= 1'b0;
                last      <= 1'b0;
            end
        end
    end

    assign load_full = !bank_open(st[0]) && !bank_open(st[1]);

endmodule

// File: tb/tb_cell_in_buffer.sv
// tb_cell_in_buffer: directed and random stimulus checked against a frame-queue reference model
module tb_cell_in_buffer;

    localparam int EB = 8;
    localparam int F  = 4;
    localparam int FB = 5;
    localparam int M  = 4 * F;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b0, clear = 1'b0, load_we = 1'b0, out_ready = 1'b0;
    logic [EB-1:0] load_data = '0;
    logic [FB-1:0] load_address = '0;
    logic [EB-1:0] gate_i, gate_f, gate_g, gate_o;
    logic [FB-1:0] feature_idx;
    logic          out_valid, last, load_full, err;

    int checks = 0;
    int passes = 0;
    bit armed = 1'b0;

    always #5 sys_clk = ~sys_clk;

    cell_in_buffer #(.ELEMENT_BITS(EB), .FEATURES(F), .FEATURE_BITS(FB)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .load_data   (load_data),
        .load_address(load_address),
        .load_we     (load_we),
        .clear       (clear),
        .gate_i      (gate_i),
        .gate_f      (gate_f),
        .gate_g      (gate_g),
        .gate_o      (gate_o),
        .feature_idx (feature_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .last        (last),
        .load_full   (load_full),
        .err         (err)
    );

    // reference: a frame being filled, a FIFO of completed frames, and the frame being presented
    logic [M*EB-1:0] fill_buf, cur_frame;
    logic [M-1:0]    fill_mask, cur_mask;
    logic [M*EB-1:0] frame_q [$];
    logic [M-1:0]    mask_q [$];
    int              fill_cnt = 0;
    int              cur_idx = 0;
    bit              cur_valid = 1'b0;
    bit              m_err = 1'b0;

    task automatic model_flush();
        frame_q.delete();
        mask_q.delete();
        cur_valid = 1'b0;
        fill_cnt  = 0;
        fill_mask = '0;
    endtask

    task automatic model_step();
        int occ;
        if (reset) begin
            model_flush();
            m_err = 1'b0;
        end else if (clear) begin
            model_flush();
        end else begin
            occ = frame_q.size() + int'(cur_valid);
            if (cur_valid && out_ready) begin
                if (cur_idx == F - 1) begin
                    if (frame_q.size() > 0) begin
                        cur_frame = frame_q.pop_front();
                        cur_mask  = mask_q.pop_front();
                        cur_idx   = 0;
                    end else
                        cur_valid = 1'b0;
                end else
                    cur_idx++;
            end else if (!cur_valid && frame_q.size() > 0) begin
                cur_frame = frame_q.pop_front();
                cur_mask  = mask_q.pop_front();
                cur_idx   = 0;
                cur_valid = 1'b1;
            end
            if (load_we) begin
                if (int'(load_address) >= M || occ == 2)
                    m_err = 1'b1;
                else begin
                    fill_buf[int'(load_address)*EB +: EB] = load_data;
                    fill_mask[int'(load_address)] = 1'b1;
                    fill_cnt++;
                    if (fill_cnt == M) begin
                        frame_q.push_back(fill_buf);
                        mask_q.push_back(fill_mask);
                        fill_cnt  = 0;
                        fill_mask = '0;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge sys_clk);
        model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge sys_clk) begin
        if (armed) begin
            chk("out_valid", 32'(out_valid), 32'(cur_valid));
            chk("load_full", 32'(load_full), 32'(frame_q.size() + int'(cur_valid) == 2));
            chk("err", 32'(err), 32'(m_err));
            if (cur_valid) begin
                chk("feature_idx", 32'(feature_idx), 32'(cur_idx));
                chk("last", 32'(last), 32'(cur_idx == F - 1));
                if (cur_mask[0*F+cur_idx]) chk("gate_i", 32'(gate_i), 32'(cur_frame[(0*F+cur_idx)*EB +: EB]));
                if (cur_mask[1*F+cur_idx]) chk("gate_f", 32'(gate_f), 32'(cur_frame[(1*F+cur_idx)*EB +: EB]));
                if (cur_mask[2*F+cur_idx]) chk("gate_g", 32'(gate_g), 32'(cur_frame[(2*F+cur_idx)*EB +: EB]));
                if (cur_mask[3*F+cur_idx]) chk("gate_o", 32'(gate_o), 32'(cur_frame[(3*F+cur_idx)*EB +: EB]));
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic wr(input int a, input int d);
        load_we      = 1'b1;
        load_address = FB'(a);
        load_data    = EB'(d);
        tick();
        load_we = 1'b0;
    endtask

    initial begin
        int p;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        armed = 1'b1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_last", 32'(last), 0);
        chk("rst_full", 32'(load_full), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_gate_i", 32'(gate_i), 0);
        chk("rst_gate_o", 32'(gate_o), 0);
        chk("rst_fidx", 32'(feature_idx), 0);

        for (int a = 0; a < M; a++) wr(a, a);
        chk("fill_latency", 32'(out_valid), 0);
        tick();
        chk("first_valid", 32'(out_valid), 1);
        chk("f0_i", 32'(gate_i), 0);
        chk("f0_f", 32'(gate_f), 4);
        chk("f0_g", 32'(gate_g), 8);
        chk("f0_o", 32'(gate_o), 12);

        for (int a = 0; a < M; a++) wr(a, 'h80 + a);
        chk("stall_f", 32'(gate_f), 4);
        chk("stall_fidx", 32'(feature_idx), 0);
        chk("both_full", 32'(load_full), 1);
        wr(5, 'hAA);
        chk("overflow_err", 32'(err), 1);

        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_fidx", 32'(feature_idx), 32'(k % 4));
            if (k == 3) begin
                chk("f3_i", 32'(gate_i), 3);
                chk("f3_f", 32'(gate_f), 7);
                chk("f3_g", 32'(gate_g), 11);
                chk("f3_o", 32'(gate_o), 15);
                chk("f3_last", 32'(last), 1);
            end
            if (k == 4) chk("b1_i0", 32'(gate_i), 'h80);
            if (k == 5) chk("b1_dropped", 32'(gate_f), 'h85);
            tick();
        end
        out_ready = 1'b0;
        chk("drained", 32'(out_valid), 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr(20, 'h55);
        chk("bad_addr_err", 32'(err), 1);
        for (int a = 0; a < M; a++) wr(a, a ^ 'h3C);
        tick();
        chk("bad_addr_uncounted", 32'(out_valid), 1);
        chk("bad_addr_i0", 32'(gate_i), 'h3C);

        out_ready = 1'b1;
        tick();
        tick();
        chk("pre_clear_fidx", 32'(feature_idx), 2);
        out_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_valid", 32'(out_valid), 0);
        chk("clear_full", 32'(load_full), 0);
        chk("clear_err_kept", 32'(err), 1);

        for (int a = 0; a < 7; a++) wr(a, 'hEE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < M; a++) wr(a, 'h40 + a);
        tick();
        chk("post_rst_i0", 32'(gate_i), 'h40);
        chk("post_rst_o0", 32'(gate_o), 'h4C);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();

        for (int ph = 0; ph < 4; ph++) begin
            p = (ph == 0) ? 90 : (ph == 1) ? 40 : (ph == 2) ? 75 : 20;
            for (int c = 0; c < 1000; c++) begin
                reset     = ($urandom % 600) == 0;
                clear     = ($urandom % 300) == 0;
                load_we   = ($urandom % 100) < 60;
                load_data = EB'($urandom);
                load_address = (($urandom % 100) < 6) ? FB'($urandom_range(16, 31))
                                                      : FB'((c + ph) % M);
                if (($urandom % 10) == 0) load_address = FB'($urandom_range(0, M - 1));
                out_ready = ($urandom % 100) < p;
                tick();
            end
        end
        reset     = 1'b0;
        clear     = 1'b0;
        load_we   = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
